regfile_mp: RTL and testbench



---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read/write ports, clear request and ready flag.
// The datapath drives through the master modport; the register file sits on the slave modport.
interface regfile_mp_if #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 32,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 1
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int NBYTE = DATAWIDTH / 8;

  logic                          clear;
  logic                          ready;
  logic [NREAD*ADDRW-1:0]        readReg;
  logic [NREAD*DATAWIDTH-1:0]    readData;
  logic [NWRITE-1:0]             write;
  logic [NWRITE*ADDRW-1:0]       writeReg;
  logic [NWRITE*NBYTE-1:0]       writeBe;
  logic [NWRITE*DATAWIDTH-1:0]   writeData;

  modport master (
    output clear, readReg, write, writeReg, writeBe, writeData,
    input  ready, readData
  );

  modport slave (
    input  clear, readReg, write, writeReg, writeBe, writeData,
    output ready, readData
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte enables, optional hardwired zero entry,
// write-first bypass and a sequential clear engine that gates ready while zeroing.
//
// state   | meaning
// S_CLEAR | clear engine zeroes entry[ptr_q] each edge; array not usable, ready low
// S_READY | normal operation; reads and effective writes allowed
module regfile_mp #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 32,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int NBYTE = DATAWIDTH / 8;
  localparam logic [ADDRW-1:0] LAST_PTR = ADDRW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                 state_q;
  logic [ADDRW-1:0]       ptr_q;
  logic                   ready_q;
  logic [DATAWIDTH-1:0]   mem_q [DEPTH];

  logic [ADDRW-1:0]       waddr [NWRITE];
  logic [NBYTE-1:0]       wbe   [NWRITE];
  logic [DATAWIDTH-1:0]   wdata [NWRITE];
  logic [NWRITE-1:0]      we_eff;

  logic [ADDRW-1:0]       raddr [NREAD];
  logic [DATAWIDTH-1:0]   rdata [NREAD];

  always_comb begin
    for (int w = 0; w < NWRITE; w++) begin
      waddr[w]  = bus.writeReg[w*ADDRW +: ADDRW];
      wbe[w]    = bus.writeBe[w*NBYTE +: NBYTE];
      wdata[w]  = bus.writeData[w*DATAWIDTH +: DATAWIDTH];
      we_eff[w] = bus.write[w] && (state_q == S_READY) && !bus.clear &&
                  !((ZERO_REG != 0) && (waddr[w] == '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (bus.clear) begin
            ptr_q <= '0;
          end else begin
            ptr_q <= ptr_q + ADDRW'(1);
            if (ptr_q == LAST_PTR) begin
              state_q <= S_READY;
              ready_q <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (bus.clear) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset of its own; the clear engine zeroes it. Later ports win per byte.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        for (int b = 0; b < NBYTE; b++) begin
          if (we_eff[w] && wbe[w][b]) begin
            mem_q[waddr[w]][b*8 +: 8] <= wdata[w][b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREAD; r++) begin
      raddr[r] = bus.readReg[r*ADDRW +: ADDRW];
      rdata[r] = mem_q[raddr[r]];
      for (int w = 0; w < NWRITE; w++) begin
        for (int b = 0; b < NBYTE; b++) begin
          if (we_eff[w] && (waddr[w] == raddr[r]) && wbe[w][b]) begin
            rdata[r][b*8 +: 8] = wdata[w][b*8 +: 8];
          end
        end
      end
      if (!ready_q || ((ZERO_REG != 0) && (raddr[r] == '0))) begin
        rdata[r] = '0;
      end
    end
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    assign bus.readData[r*DATAWIDTH +: DATAWIDTH] = rdata[r];
  end

  assign bus.ready = ready_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (32x32, 2 read / 2 write ports, hardwired zero entry).
// Expected values come from a behavioural array model through a scoreboard queue.
module tb_regfile_mp;
  logic clk;
  logic rst_n;

  regfile_mp_if #(.DATAWIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2)) rf_if ();

  regfile_mp #(.DATAWIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int checks;
  int errors;

  function automatic logic [31:0] rd(input int p);
    return rf_if.readData[p*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rf_if.clear     = 1'b0;
    rf_if.write     = '0;
    rf_if.writeReg  = '0;
    rf_if.writeBe   = '0;
    rf_if.writeData = '0;
  endtask

  task automatic set_read(input int p, input logic [4:0] a);
    rf_if.readReg[p*5 +: 5] = a;
  endtask

  task automatic set_write(input int p, input logic [4:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    rf_if.write[p]            = 1'b1;
    rf_if.writeReg[p*5 +: 5]  = a;
    rf_if.writeBe[p*4 +: 4]   = be;
    rf_if.writeData[p*32 +: 32] = d;
  endtask

  // Model update for an effective write; call in port order so the later port wins per byte.
  task automatic model_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    if (a != 5'd0) begin
      for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic wait_ready_after_reset(input string tag);
    int edges;
    edges = 0;
    while (edges < 40) begin
      tick();
      edges++;
      if (edges == 31) begin
        checks++;
        if (rf_if.ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_ready_early: ready=%b after 31 edges, required 0", tag, rf_if.ready);
        end
      end
      if (rf_if.ready === 1'b1) break;
    end
    checks++;
    if (edges != 32) begin
      errors++;
      $display("FAIL %s_ready_latency: ready after %0d edges, required 32", tag, edges);
    end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst_n = 1'b0;
    set_idle();
    rf_if.readReg = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    repeat (3) tick();
    set_read(0, 5'd3);
    #2;
    checks++;
    if (rf_if.ready !== 1'b0 || rd(0) !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b data=%h, required 0/00000000", rf_if.ready, rd(0));
    end
    rst_n = 1'b1;
    wait_ready_after_reset("reset");
    for (int a = 0; a < 32; a += 2) begin
      set_read(0, 5'(a));
      set_read(1, 5'(a + 1));
      exp_q.push_back(model[a]);
      exp_q.push_back(model[a+1]);
      #2;
      for (int p = 0; p < 2; p++) begin
        e = exp_q.pop_front();
        checks++;
        if (rd(p) !== e) begin
          errors++;
          $display("FAIL reset_zero r%0d: got %h, required %h", a + p, rd(p), e);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    set_write(0, 5'd5, 4'hF, 32'hDEADBEEF);
    model_write(5'd5, 4'hF, 32'hDEADBEEF);
    set_read(0, 5'd5);
    exp_q.push_back(32'hDEADBEEF);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(0) !== e) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h, required %h", rd(0), e);
    end
    tick();
    set_idle();
    exp_q.push_back(model[5]);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(0) !== e) begin
      errors++;
      $display("FAIL bypass_next_cycle: got %h, required %h", rd(0), e);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] e;
    set_write(0, 5'd7, 4'hF, 32'h11223344);
    model_write(5'd7, 4'hF, 32'h11223344);
    tick();
    set_write(0, 5'd7, 4'b0101, 32'hAABBCCDD);
    model_write(5'd7, 4'b0101, 32'hAABBCCDD);
    set_read(1, 5'd7);
    exp_q.push_back(32'h11BB33DD);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(1) !== e) begin
      errors++;
      $display("FAIL byte_enable_bypass: got %h, required %h", rd(1), e);
    end
    tick();
    set_idle();
    exp_q.push_back(model[7]);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(1) !== e) begin
      errors++;
      $display("FAIL byte_enable_stored: got %h, required %h", rd(1), e);
    end
  endtask

  task automatic test_dual_write();
    logic [31:0] e;
    set_write(0, 5'd9, 4'hF, 32'h00000001);
    set_write(1, 5'd9, 4'b1100, 32'hFFFF0000);
    model_write(5'd9, 4'hF, 32'h00000001);
    model_write(5'd9, 4'b1100, 32'hFFFF0000);
    set_read(0, 5'd9);
    exp_q.push_back(32'hFFFF0001);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(0) !== e) begin
      errors++;
      $display("FAIL dual_write_bypass: got %h, required %h", rd(0), e);
    end
    tick();
    set_idle();
    exp_q.push_back(model[9]);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(0) !== e) begin
      errors++;
      $display("FAIL dual_write_stored: got %h, required %h", rd(0), e);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] e;
    set_write(0, 5'd0, 4'hF, 32'h12345678);
    set_read(0, 5'd0);
    exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(0) !== e) begin
      errors++;
      $display("FAIL zero_reg_same_cycle: got %h, required %h", rd(0), e);
    end
    tick();
    set_idle();
    exp_q.push_back(model[0]);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(0) !== e) begin
      errors++;
      $display("FAIL zero_reg_stored: got %h, required %h", rd(0), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] d0, d1;
    logic [3:0]  be0, be1;
    logic [4:0]  a, prev;
    for (int i = 0; i < 12; i++) begin
      a    = 5'(10 + i);
      prev = 5'(9 + i);
      d0   = $urandom;
      d1   = $urandom;
      be0  = 4'($urandom_range(1, 15));
      be1  = 4'($urandom_range(0, 15));
      set_write(0, a, be0, d0);
      set_write(1, a, be1, d1);
      model_write(a, be0, d0);
      model_write(a, be1, d1);
      set_read(0, prev);
      set_read(1, a);
      exp_q.push_back(model[prev]);
      exp_q.push_back(model[a]);
      #2;
      for (int p = 0; p < 2; p++) begin
        e = exp_q.pop_front();
        checks++;
        if (rd(p) !== e) begin
          errors++;
          $display("FAIL back_to_back i=%0d port%0d: got %h, required %h", i, p, rd(p), e);
        end
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_clear();
    logic [31:0] e;
    for (int a = 1; a < 32; a++) begin
      set_write(0, 5'(a), 4'hF, 32'hA5000000 | 32'(a));
      model_write(5'(a), 4'hF, 32'hA5000000 | 32'(a));
      tick();
    end
    set_idle();
    rf_if.clear = 1'b1;
    set_write(0, 5'd3, 4'hF, 32'h00000055);
    set_read(0, 5'd3);
    exp_q.push_back(model[3]);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rd(0) !== e || rf_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_cycle_write: got %h ready=%b, required %h ready=1", rd(0), rf_if.ready, e);
    end
    tick();
    rf_if.clear = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      #2;
      checks++;
      if (rf_if.ready !== 1'b0 || rd(0) !== 32'h0) begin
        errors++;
        $display("FAIL clear_busy t+%0d: ready=%b data=%h, required 0/00000000", k, rf_if.ready, rd(0));
      end
      tick();
    end
    set_idle();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #2;
    checks++;
    if (rf_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_ready_back: ready=%b, required 1", rf_if.ready);
    end
    for (int a = 0; a < 32; a += 2) begin
      set_read(0, 5'(a));
      set_read(1, 5'(a + 1));
      exp_q.push_back(model[a]);
      exp_q.push_back(model[a+1]);
      #2;
      for (int p = 0; p < 2; p++) begin
        e = exp_q.pop_front();
        checks++;
        if (rd(p) !== e) begin
          errors++;
          $display("FAIL clear_zero r%0d: got %h, required %h", a + p, rd(p), e);
        end
      end
    end
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] e;
    set_write(0, 5'd12, 4'hF, 32'hCAFEF00D);
    set_read(0, 5'd12);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_if.ready !== 1'b0 || rd(0) !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: ready=%b data=%h, required 0/00000000", rf_if.ready, rd(0));
    end
    tick();
    set_idle();
    tick();
    rst_n = 1'b1;
    wait_ready_after_reset("midreset");
    set_read(0, 5'd12);
    set_read(1, 5'd5);
    exp_q.push_back(model[12]);
    exp_q.push_back(model[5]);
    #2;
    for (int p = 0; p < 2; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd(p) !== e) begin
        errors++;
        $display("FAIL midreset_zero port%0d: got %h, required %h", p, rd(p), e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_byte_enable();
    test_dual_write();
    test_zero_reg();
    test_back_to_back();
    test_clear();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
